// File: rtl/yolo_pool_pkg.sv
// Shared helpers for the pooling stages: the max compare and the line-buffer depth.
// Signedness of every compare is chosen by MAXPOOL_SIGNED_EN (unsigned when undefined).
package yolo_pool_pkg;

    // Compares run on a fixed wide word; callers sign- or zero-extend their samples.
    localparam int MAX_W     = 32;
    localparam int DEF_IMG_W = 16;
    localparam int LB_DEPTH  = DEF_IMG_W / 2;

    function automatic logic [MAX_W-1:0] pool_max(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
        return ($signed(a) >= $signed(b)) ? a : b;
`else
        return (a >= b) ? a : b;
`endif
    endfunction

endpackage

// File: rtl/pool_max_ch.sv
// Per-channel max of two packed CH*DATA_W vectors (MAXPOOL_SIGNED_EN selects signed compare).
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module pool_max_ch
    import yolo_pool_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CH     = 4
) (
    input  logic [CH*DATA_W-1:0] a,
    input  logic [CH*DATA_W-1:0] b,
    output logic [CH*DATA_W-1:0] y
);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [MAX_W-1:0] ea;
        logic [MAX_W-1:0] eb;
`ifdef MAXPOOL_SIGNED_EN
        assign ea = MAX_W'($signed(a[c*DATA_W +: DATA_W]));
        assign eb = MAX_W'($signed(b[c*DATA_W +: DATA_W]));
`else
        assign ea = MAX_W'(a[c*DATA_W +: DATA_W]);
        assign eb = MAX_W'(b[c*DATA_W +: DATA_W]);
`endif
        assign y[c*DATA_W +: DATA_W] = DATA_W'(pool_max(ea, eb));
    end

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over raster pixels; MAXPOOL_SIGNED_EN makes compares signed.
// Latency: out_valid rises one cycle after the bottom-right pixel of a window is accepted.
// Backpressure: only window-completing beats stall, and only while a held result is unread.
module maxpool2x2_stream
    import yolo_pool_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CH     = 4,
    parameter int IMG_W  = 2 * LB_DEPTH,
    parameter int IMG_H  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*DATA_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*DATA_W-1:0] out_data,
    output logic                 out_last
);

    localparam int DW    = CH * DATA_W;
    localparam int DEPTH = IMG_W / 2;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [DW-1:0] hreg;
    logic [DW-1:0] pair;
    logic [DW-1:0] pooled;
    logic [DW-1:0] lb_rd;
    logic [DW-1:0] linebuf [DEPTH];
    logic [AW-1:0] lb_idx;
    logic          win_beat;
    logic          col_last;
    logic          row_last;
    logic          accept;

    assign lb_idx   = AW'(col >> 1);
    assign lb_rd    = linebuf[lb_idx];
    assign win_beat = row[0] & col[0];
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign in_ready = !win_beat || !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !clear;

    pool_max_ch #(.DATA_W(DATA_W), .CH(CH)) u_hmax (
        .a (hreg),
        .b (in_data),
        .y (pair)
    );

    pool_max_ch #(.DATA_W(DATA_W), .CH(CH)) u_vmax (
        .a (lb_rd),
        .b (pair),
        .y (pooled)
    );

    // Contents are always written on an even row before an odd row reads them.
    always_ff @(posedge clk) begin
        if (accept && col[0] && !row[0]) begin
            linebuf[lb_idx] <= pair;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            hreg      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (clear) begin
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (!col[0]) begin
                    hreg <= in_data;
                end
                if (win_beat) begin
                    out_data  <= pooled;
                    out_valid <= 1'b1;
                    out_last  <= row_last && col_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream on a 4x4 single-channel frame.
module tb_maxpool2x2_stream;

    localparam int DATA_W = 8;
    localparam int CH     = 1;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [DATA_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [DATA_W-1:0] out_data;
    logic             out_last;

    int n_cmp = 0;
    int n_err = 0;
    int stall_cnt = 0;
    logic [7:0] out_q[$];
    bit         last_q[$];
    int         pix[16];

    maxpool2x2_stream #(.DATA_W(DATA_W), .CH(CH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            out_q.push_back(out_data);
            last_q.push_back(out_last);
        end
        if (rst_n && in_valid && !in_ready) stall_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input int v);
        bit acc;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = DATA_W'(v);
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 100) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic send_frame();
        for (int i = 0; i < 16; i++) send(pix[i]);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_frame(input string tag, input int base,
                             input int e0, input int e1, input int e2, input int e3);
        int e[4];
        logic [31:0] g;
        logic [31:0] gl;
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            g  = 'x;
            gl = 'x;
            if (out_q.size() > base + i) begin
                g  = 32'(out_q[base + i]);
                gl = 32'(last_q[base + i]);
            end
            chk($sformatf("%s_d%0d", tag, i), g, 32'(e[i]));
            chk($sformatf("%s_l%0d", tag, i), gl, (i == 3) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic reset_q();
        out_q.delete();
        last_q.delete();
        stall_cnt = 0;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", 32'(out_valid), 0);
        chk("rst_dat", 32'(out_data), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_rdy", 32'(in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Frame 1..16, checking latency after the first window's last beat
        reset_q();
        for (int i = 0; i < 16; i++) begin
            send(i + 1);
            if (i == 5) begin
                chk("lat_vld", 32'(out_valid), 1);
                chk("lat_dat", 32'(out_data), 6);
            end
        end
        drain();
        chk("f1_cnt", out_q.size(), 4);
        chk_frame("f1", 0, 6, 8, 14, 16);
        chk("f1_stall", stall_cnt, 0);

        // Winner of value 100 placed at a different corner in each window
        reset_q();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                int p, w;
                p = (r % 2) * 2 + (c % 2);
                w = (r / 2) * 2 + (c / 2);
                pix[r*4+c] = (p == w) ? 100 : 10 * (p + 1);
            end
        send_frame();
        drain();
        chk_frame("pos", 0, 100, 100, 100, 100);

        reset_q();
        for (int i = 0; i < 16; i++) pix[i] = 50;
        send_frame();
        drain();
        chk_frame("eq", 0, 50, 50, 50, 50);

        // Backpressure while window 0 is held
        reset_q();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(i + 1);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d", k), 32'(out_data), 6);
        end
        @(posedge clk); #1;
        send(7);
        in_valid = 1'b1;
        in_data  = 8'd8;
        @(negedge clk);
        chk("bp_stall", 32'(in_ready), 0);
        chk("bp_vld", 32'(out_valid), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 7; i < 16; i++) send(i + 1);
        drain();
        chk("bp_cnt", out_q.size(), 4);
        chk_frame("bp", 0, 6, 8, 14, 16);
        chk("bp_stalls", stall_cnt, 1);

        // Two frames back to back with no idle cycle
        reset_q();
        for (int i = 0; i < 32; i++) send(i + 1);
        drain();
        chk("b2b_cnt", out_q.size(), 8);
        chk_frame("b2b0", 0, 6, 8, 14, 16);
        chk_frame("b2b1", 4, 22, 24, 30, 32);
        chk("b2b_stall", stall_cnt, 0);

        // clear mid-frame with a beat presented in the same cycle
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(i + 1);
        clear = 1'b1; in_valid = 1'b1; in_data = 8'd99;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_vld", 32'(out_valid), 0);
        chk("clr_last", 32'(out_last), 0);
        reset_q();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) pix[i] = 201 + i;
        send_frame();
        drain();
        chk("clr_cnt", out_q.size(), 4);
        chk_frame("clr", 0, 206, 208, 214, 216);

        // Signedness corner
        reset_q();
        for (int i = 0; i < 16; i++) pix[i] = 0;
        pix[0] = 8'h80; pix[1] = 8'h7F; pix[4] = 8'h01; pix[5] = 8'h00;
        send_frame();
        drain();
`ifdef MAXPOOL_SIGNED_EN
        chk_frame("sgn", 0, 8'h7F, 0, 0, 0);
`else
        chk_frame("sgn", 0, 8'h80, 0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
